// File: rtl/fa_pkg.sv
// Shared definitions for the fa_triad full-adder cross-check block.
// Reference function and case-cell truth table.
package fa_pkg;

  // Indexed by {ci,a,b}; each 2-bit slot holds {co,s}.
  localparam logic [15:0] FA_TT = 16'b11_10_10_01_10_01_01_00;

  function automatic logic [1:0] fa_ref(
    input logic a,
    input logic b,
    input logic ci
  );
    logic [1:0] r;
    r = {1'b0, a} + {1'b0, b} + {1'b0, ci};
    return r;
  endfunction

endpackage

// File: rtl/fa_triad_cells.sv
// Three independently coded 1-bit full-adder cells.
// Dataflow, behavioral and case-table flavours.
module fa_dataflow (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module fa_behavior (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  // Plain 2-bit addition of the three inputs.
  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {1'b0, ci};
  end
endmodule

module fa_case
  import fa_pkg::*;
(
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  // Truth-table lookup on {ci,a,b}.
  always_comb begin
    {co, s} = 2'b00;
    case ({ci, a, b})
      3'd0: {co, s} = FA_TT[1:0];
      3'd1: {co, s} = FA_TT[3:2];
      3'd2: {co, s} = FA_TT[5:4];
      3'd3: {co, s} = FA_TT[7:6];
      3'd4: {co, s} = FA_TT[9:8];
      3'd5: {co, s} = FA_TT[11:10];
      3'd6: {co, s} = FA_TT[13:12];
      3'd7: {co, s} = FA_TT[15:14];
      default: {co, s} = 2'b00;
    endcase
  end
endmodule

// File: rtl/fa_triad.sv
// Registered triple full-adder with cross-check flag.
// Three ripple chains, one output register stage.
module fa_triad
  import fa_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  output logic [WIDTH-1:0] s1,
  output logic             co1,
  output logic [WIDTH-1:0] s2,
  output logic             co2,
  output logic [WIDTH-1:0] s3,
  output logic             co3,
  output logic             mismatch
);

  logic [WIDTH-1:0] s1c, s2c, s3c;
  logic [WIDTH:0]   c1, c2, c3;
  logic             diff;

  assign c1[0] = ci;
  assign c2[0] = ci;
  assign c3[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_dataflow u_df (
      .s  (s1c[i]),
      .co (c1[i+1]),
      .a  (a[i]),
      .b  (b[i]),
      .ci (c1[i])
    );
    fa_behavior u_bh (
      .s  (s2c[i]),
      .co (c2[i+1]),
      .a  (a[i]),
      .b  (b[i]),
      .ci (c2[i])
    );
    fa_case u_cs (
      .s  (s3c[i]),
      .co (c3[i+1]),
      .a  (a[i]),
      .b  (b[i]),
      .ci (c3[i])
    );
  end

  assign diff = ({s1c, c1[WIDTH]} != {s2c, c2[WIDTH]})
             || ({s1c, c1[WIDTH]} != {s3c, c3[WIDTH]});

  // Capture all three results; hold data when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s1        <= '0;
      co1       <= 1'b0;
      s2        <= '0;
      co2       <= 1'b0;
      s3        <= '0;
      co3       <= 1'b0;
      mismatch  <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      s1        <= s1c;
      co1       <= c1[WIDTH];
      s2        <= s2c;
      co2       <= c2[WIDTH];
      s3        <= s3c;
      co3       <= c3[WIDTH];
      mismatch  <= diff;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fa_triad.sv
// Bench for fa_triad at WIDTH=1 and WIDTH=4.
// Random and directed stimulus against an arithmetic model.
module tb_fa_triad;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a4, b4;
  logic       ci;

  logic       ov1, co11, co21, co31, mm1;
  logic [0:0] s11, s21, s31;
  logic       ov4, co14, co24, co34, mm4;
  logic [3:0] s14, s24, s34;

  int checks = 0;
  int failures = 0;

  logic       m1_v, m1_s, m1_co;
  logic       m4_v, m4_co;
  logic [3:0] m4_s;

  always #5 clk = ~clk;

  fa_triad #(.WIDTH(1)) u_w1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a4[0:0]),
    .b         (b4[0:0]),
    .ci        (ci),
    .out_valid (ov1),
    .s1        (s11),
    .co1       (co11),
    .s2        (s21),
    .co2       (co21),
    .s3        (s31),
    .co3       (co31),
    .mismatch  (mm1)
  );

  fa_triad #(.WIDTH(4)) u_w4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a4),
    .b         (b4),
    .ci        (ci),
    .out_valid (ov4),
    .s1        (s14),
    .co1       (co14),
    .s2        (s24),
    .co2       (co24),
    .s3        (s34),
    .co3       (co34),
    .mismatch  (mm4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("w1.ov",  32'(ov1),  32'(m1_v));
    chk("w1.s1",  32'(s11),  32'(m1_s));
    chk("w1.co1", 32'(co11), 32'(m1_co));
    chk("w1.s2",  32'(s21),  32'(m1_s));
    chk("w1.co2", 32'(co21), 32'(m1_co));
    chk("w1.s3",  32'(s31),  32'(m1_s));
    chk("w1.co3", 32'(co31), 32'(m1_co));
    chk("w1.mm",  32'(mm1),  32'd0);
    chk("w4.ov",  32'(ov4),  32'(m4_v));
    chk("w4.s1",  32'(s14),  32'(m4_s));
    chk("w4.co1", 32'(co14), 32'(m4_co));
    chk("w4.s2",  32'(s24),  32'(m4_s));
    chk("w4.co2", 32'(co24), 32'(m4_co));
    chk("w4.s3",  32'(s34),  32'(m4_s));
    chk("w4.co3", 32'(co34), 32'(m4_co));
    chk("w4.mm",  32'(mm4),  32'd0);
  endtask

  task automatic step(input logic r, input logic iv,
                      input logic [3:0] av, input logic [3:0] bv,
                      input logic cv);
    int sum1, sum4;
    rst = r;
    in_valid = iv;
    a4 = av;
    b4 = bv;
    ci = cv;
    @(posedge clk);
    #1;
    sum1 = int'(av[0]) + int'(bv[0]) + int'(cv);
    sum4 = int'(av) + int'(bv) + int'(cv);
    if (r) begin
      m1_v = 0; m1_s = 0; m1_co = 0;
      m4_v = 0; m4_s = 0; m4_co = 0;
    end else if (iv) begin
      m1_v = 1; m1_s = sum1[0]; m1_co = sum1[1];
      m4_v = 1; m4_s = sum4[3:0]; m4_co = sum4[4];
    end else begin
      m1_v = 0;
      m4_v = 0;
    end
    check_all();
  endtask

  initial begin
    logic [2:0] k3;
    rst = 1'b1; in_valid = 1'b0;
    a4 = '0; b4 = '0; ci = 1'b0;

    step(1, 1, 4'h1, 4'h1, 1);
    step(1, 1, 4'h1, 4'h1, 1);

    for (int k = 0; k < 8; k++) begin
      k3 = 3'(k);
      step(0, 1, {3'b0, k3[1]}, {3'b0, k3[0]}, k3[2]);
    end
    chk("sweep.last.s", 32'(s11), 32'd1);
    chk("sweep.last.co", 32'(co11), 32'd1);

    step(0, 0, 4'h0, 4'h1, 1);
    chk("hold.s", 32'(s11), 32'd1);
    chk("hold.co", 32'(co11), 32'd1);

    step(0, 1, 4'h3, 4'h5, 0);
    step(1, 1, 4'h1, 4'h1, 0);

    step(0, 1, 4'hF, 4'h0, 1);
    chk("ripple1.s", 32'(s34), 32'h0);
    chk("ripple1.co", 32'(co34), 32'd1);
    step(0, 1, 4'h7, 4'h8, 0);
    chk("ripple2.s", 32'(s24), 32'hF);
    chk("ripple2.co", 32'(co24), 32'd0);

    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom),
           1'($urandom));
    end

    force u_w4.s3c = 4'h1;
    rst = 0; in_valid = 1; a4 = 4'h0; b4 = 4'h0; ci = 0;
    @(posedge clk);
    #1;
    chk("force.mm", 32'(mm4), 32'd1);
    chk("force.ov", 32'(ov4), 32'd1);
    chk("force.s1", 32'(s14), 32'h0);
    chk("force.s3", 32'(s34), 32'h1);
    release u_w4.s3c;
    step(1, 0, 4'h0, 4'h0, 0);
    step(0, 1, 4'h2, 4'h3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
